// File: rtl/time_display_driver.sv
// Four-digit multiplexed 7-segment driver showing MM.SS.
// A frame-synchronous latch feeds a sequential divide-by-10 BCD converter. Its result is
// committed to display registers that the digit scanner reads, so a frame never shows torn time.
module time_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          DP_BLINK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] minute,
  input  logic [6:0] second,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned     CntW   = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  // Digit code 4'hf doubles as the overflow marker and renders as a dash.
  localparam logic [3:0]      DigDash = 4'hf;

  typedef enum logic [2:0] {StIdle, StLatch, StConvMin, StConvSec, StCommit} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            first_q, first_d;
  logic [6:0]      rem_q, rem_d;
  logic [6:0]      sec_hold_q, sec_hold_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic            disp_dp_q, disp_dp_d;
  logic            vld_q, vld_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            frame_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Refresh counter and digit index advance.
  always_comb begin
    cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    idx_d     = (cnt_q == CntMax) ? idx_q + 2'd1 : idx_q;
    frame_end = (idx_q == 2'd3) && (cnt_q == CntMax);
  end

  // Converter FSM: latch once per frame, divide each field by repeated subtraction, commit.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    rem_d      = rem_q;
    sec_hold_d = sec_hold_q;
    tens_d     = tens_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    vld_d      = vld_q;
    unique case (state_q)
      StIdle: begin
        if (first_q || frame_end) state_d = StLatch;
      end
      StLatch: begin
        rem_d      = minute;
        sec_hold_d = second;
        tens_d     = '0;
        first_d    = 1'b0;
        state_d    = StConvMin;
      end
      StConvMin: begin
        if (rem_q > 7'd99) begin
          min_tens_d = DigDash;
          min_ones_d = DigDash;
          rem_d      = sec_hold_q;
          tens_d     = '0;
          state_d    = StConvSec;
        end else if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          min_tens_d = tens_q;
          min_ones_d = rem_q[3:0];
          rem_d      = sec_hold_q;
          tens_d     = '0;
          state_d    = StConvSec;
        end
      end
      StConvSec: begin
        if (rem_q > 7'd99) begin
          sec_tens_d = DigDash;
          sec_ones_d = DigDash;
          state_d    = StCommit;
        end else if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          sec_tens_d = tens_q;
          sec_ones_d = rem_q[3:0];
          state_d    = StCommit;
        end
      end
      StCommit: begin
        disp_d    = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
        disp_dp_d = sec_hold_q[0];
        vld_d     = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode aligned with the next counter value so the registered outputs track cnt.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (vld_q && (cnt_d != '0)) begin
      an_d[idx_d] = 1'b0;
      seg_d       = seg_decode(disp_q[idx_d]);
      dp_d        = !(DP_BLINK && (idx_d == 2'd2) && !disp_dp_q);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      first_q    <= 1'b1;
      rem_q      <= '0;
      sec_hold_q <= '0;
      tens_q     <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      disp_q     <= '0;
      disp_dp_q  <= 1'b0;
      vld_q      <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      rem_q      <= rem_d;
      sec_hold_q <= sec_hold_d;
      tens_q     <= tens_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      vld_q      <= vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver: table vectors, hand sequences, random inputs, and a
// cycle-by-cycle frame-level reference model applied to a DP_BLINK=1 and a DP_BLINK=0 instance.
module tb_time_display_driver;

  localparam int Div    = 32;
  localparam int Frame  = 4 * Div;
  // Latch + 22-cycle worst-case conversion + output register: new digits are guaranteed here.
  localparam int Settle = 24;

  localparam logic [6:0] SegTbl [11] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111};

  typedef struct packed {
    logic [6:0]      mn;
    logic [6:0]      sc;
    logic [3:0][6:0] seg;  // indexed by slot: [0]=sec ones .. [3]=min tens
    logic            dp2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] minute = '0;
  logic [6:0] second = '0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int          vectors = 0;
  int          errors = 0;
  int unsigned edges = 0;
  int          cur_min = 0, cur_sec = 0, prev_min = 0, prev_sec = 0;
  bit          have_prev = 1'b0;
  vec_t        tbl [7];

  time_display_driver #(.REFRESH_DIV(Div), .DP_BLINK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .minute(minute), .second(second),
    .an(an_a), .seg(seg_a), .dp(dp_a));

  time_display_driver #(.REFRESH_DIV(Div), .DP_BLINK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .minute(minute), .second(second),
    .an(an_b), .seg(seg_b), .dp(dp_b));

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic int digit_of(input int val, input bit tens);
    if (val > 99) return 10;
    return tens ? val / 10 : val % 10;
  endfunction

  function automatic int slot_digit(input int mn, input int sc, input int slot);
    case (slot)
      0:       return digit_of(sc, 1'b0);
      1:       return digit_of(sc, 1'b1);
      2:       return digit_of(mn, 1'b0);
      default: return digit_of(mn, 1'b1);
    endcase
  endfunction

  task automatic check_slot(input string tag, input logic [3:0] an_v, input logic [6:0] seg_v,
                            input logic dp_v, input bit blink, input int slot, input int pos);
    logic [3:0] an_on;
    logic [6:0] seg_new, seg_old;
    logic       dp_e;
    bit         startup, transit, ok;
    an_on       = 4'b1111;
    an_on[slot] = 1'b0;
    seg_new = SegTbl[slot_digit(cur_min, cur_sec, slot)];
    seg_old = have_prev ? SegTbl[slot_digit(prev_min, prev_sec, slot)] : seg_new;
    startup = !have_prev && slot == 0 && pos < Settle;
    transit = slot == 0 && pos < Settle;
    dp_e    = !(blink && slot == 2 && pos != 0 && (cur_sec % 2) == 0);
    if (pos == 0)              ok = (an_v == 4'b1111) && dp_v;
    else if (an_v == 4'b1111) ok = startup && dp_v;
    else ok = (an_v == an_on) && (dp_v == dp_e) &&
              ((seg_v == seg_new) || (transit && seg_v == seg_old));
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_%s k=%0d slot=%0d pos=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               tag, edges, slot, pos, an_v, seg_v, dp_v, (pos == 0) ? 4'b1111 : an_on,
               seg_new, dp_e);
    end
  endtask

  // Frame-level reference model: inputs seen at a frame start are what that frame displays.
  always @(negedge clk) begin
    int slot, pos;
    if (rst_n && edges >= 1) begin
      slot = int'((edges / Div) % 4);
      pos  = int'(edges % Div);
      if (edges == 1) begin
        cur_min   = int'(minute);
        cur_sec   = int'(second);
        have_prev = 1'b0;
      end else if (slot == 0 && pos == 0) begin
        prev_min  = cur_min;
        prev_sec  = cur_sec;
        cur_min   = int'(minute);
        cur_sec   = int'(second);
        have_prev = 1'b1;
      end
      check_slot("a", an_a, seg_a, dp_a, 1'b1, slot, pos);
      check_slot("b", an_b, seg_b, dp_b, 1'b0, slot, pos);
    end
  end

  task automatic wait_point(input int slot, input int pos);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 2 * Frame) begin
      @(negedge clk);
      n++;
      hit = rst_n && int'(edges % Div) == pos && int'((edges / Div) % 4) == slot;
    end
    if (!hit) begin
      vectors++;
      errors++;
      $display("FAIL wait_point: slot %0d pos %0d not reached, got timeout, want hit", slot, pos);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] an_v, input logic [6:0] seg_v,
                            input logic dp_v, input logic [3:0] an_e, input logic [6:0] seg_e,
                            input logic dp_e);
    vectors++;
    if (an_v !== an_e || seg_v !== seg_e || dp_v !== dp_e) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, an_v, seg_v, dp_v, an_e, seg_e, dp_e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_an;
    tbl[0] = '{7'd12,  7'd34,  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
    tbl[1] = '{7'd59,  7'd59,  {7'b0010010, 7'b0010000, 7'b0010010, 7'b0010000}, 1'b1};
    tbl[2] = '{7'd100, 7'd7,   {7'b0111111, 7'b0111111, 7'b1000000, 7'b1111000}, 1'b1};
    tbl[3] = '{7'd45,  7'd0,   {7'b0011001, 7'b0010010, 7'b1000000, 7'b1000000}, 1'b0};
    tbl[4] = '{7'd99,  7'd60,  {7'b0010000, 7'b0010000, 7'b0000010, 7'b1000000}, 1'b0};
    tbl[5] = '{7'd0,   7'd127, {7'b1000000, 7'b1000000, 7'b0111111, 7'b0111111}, 1'b1};
    tbl[6] = '{7'd68,  7'd18,  {7'b0000010, 7'b0000000, 7'b1111001, 7'b0000000}, 1'b0};

    // Reset values.
    minute = 7'd12;
    second = 7'd34;
    #12;
    expect_out("reset_a", an_a, seg_a, dp_a, 4'b1111, 7'b1111111, 1'b1);
    expect_out("reset_b", an_b, seg_b, dp_b, 4'b1111, 7'b1111111, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: change in slot 1, check every slot of the following frame.
    for (int i = 0; i < 7; i++) begin
      wait_point(1, 5);
      minute = tbl[i].mn;
      second = tbl[i].sc;
      wait_point(0, 1);
      for (int s = 0; s < 4; s++) begin
        wait_point(s, Div - 2);
        exp_an    = 4'b1111;
        exp_an[s] = 1'b0;
        expect_out($sformatf("vec%0d_slot%0d", i, s), an_a, seg_a, dp_a, exp_an, tbl[i].seg[s],
                   (s == 2) ? tbl[i].dp2 : 1'b1);
      end
    end

    // Mid-frame minute change is held off until the next frame.
    wait_point(1, 5);
    minute = 7'd12;
    second = 7'd34;
    wait_point(0, 2);
    wait_point(1, 5);
    minute = 7'd45;
    wait_point(3, 10);
    expect_out("midframe_old", an_a, seg_a, dp_a, 4'b0111, 7'b1111001, 1'b1);
    wait_point(3, 10);
    expect_out("midframe_new", an_a, seg_a, dp_a, 4'b0111, 7'b0011001, 1'b1);

    // Asynchronous reset while the converter is busy.
    wait_point(0, 4);
    #2 rst_n = 1'b0;
    #1;
    expect_out("midreset_a", an_a, seg_a, dp_a, 4'b1111, 7'b1111111, 1'b1);
    expect_out("midreset_b", an_b, seg_b, dp_b, 4'b1111, 7'b1111111, 1'b1);
    minute = 7'd23;
    second = 7'd41;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_point(0, Settle + 2);
    expect_out("postreset_s1", an_a, seg_a, dp_a, 4'b1110, 7'b1111001, 1'b1);
    wait_point(3, 10);
    expect_out("postreset_m10", an_a, seg_a, dp_a, 4'b0111, 7'b0100100, 1'b1);

    // Random inputs at random points outside the frame-start slot.
    for (int i = 0; i < 20; i++) begin
      wait_point(1 + int'($urandom_range(0, 2)), int'($urandom_range(1, Div - 1)));
      if ($urandom_range(0, 1) == 0) begin
        minute = 7'($urandom_range(0, 59));
        second = 7'($urandom_range(0, 59));
      end else begin
        minute = 7'($urandom_range(0, 127));
        second = 7'($urandom_range(0, 127));
      end
      repeat (1 + $urandom_range(0, 1)) wait_point(0, 5);
    end
    wait_point(0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
